// File: rtl/lockpick_key_loader.sv
// rtl/lockpick_key_loader.sv - buffers a key pair, streams it into lockpick_game and summarises each attempt
//
// Purpose: accepts 2*KEY_BYTES bytes (key A then key B) from a valid/ready
// host source, issues a start pulse when no session is open, streams the
// buffered bytes into the game with BYTE_GAP idle cycles between bytes,
// then counts the game's 32-cycle result burst and reports one summary.
// An error status keeps the session open so the next pair retries without
// a new start.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid, in_data   host byte stream
//   in_ready            high while filling the pair buffer
//   start               one-cycle pulse opening a game session
//   input_enable        byte strobe to the game
//   input_data          byte to the game, zero when input_enable is low
//   game_output_valid   game result burst strobe
//   game_status         game status, sampled on the first burst cycle
//   busy                high whenever the loader is not filling
//   result_valid        one-cycle pulse per completed attempt
//   result_status       captured status of the last attempt
//   attempt_count       attempts completed in the current session
module lockpick_key_loader #(
  parameter int KEY_BYTES = 32,
  parameter int BYTE_GAP  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       start,
  output logic       input_enable,
  output logic [7:0] input_data,
  input  logic       game_output_valid,
  input  logic [1:0] game_status,
  output logic       busy,
  output logic       result_valid,
  output logic [1:0] result_status,
  output logic [1:0] attempt_count
);

  localparam int NB = 2 * KEY_BYTES;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [3:0] GAP = 4'(BYTE_GAP);

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_SEND,
    S_WAIT,
    S_REPORT
  } state_e;

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] cap_q, cap_d;
  logic sess_q, sess_d;
  logic [1:0] att_q, att_d;
  logic [1:0] res_status_q, res_status_d;
  logic buf_we;

  logic in_ready_q, in_ready_d;
  logic start_q, start_d;
  logic en_q, en_d;
  logic [7:0] data_q, data_d;
  logic busy_q, busy_d;
  logic rv_q, rv_d;

  logic [7:0] mem_q [NB];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    sess_d       = sess_q;
    att_d        = att_q;
    res_status_d = res_status_q;
    buf_we       = 1'b0;

    case (state_q)
      S_FILL: begin
        if (in_valid && in_ready_q) begin
          buf_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            gap_d   = '0;
            // A retry goes straight to SEND: the game is already waiting for key A.
            state_d = sess_q ? S_SEND : S_START;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_START: begin
        sess_d  = 1'b1;
        att_d   = 2'd0;
        idx_d   = '0;
        gap_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (gap_q == 4'd0) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            idx_d = idx_q + IW'(1);
            gap_d = GAP;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_WAIT: begin
        if (game_output_valid) begin
          if (cnt_q == 5'd0) begin
            cap_d = game_status;
          end
          if (cnt_q == 5'd31) begin
            cnt_d        = '0;
            att_d        = att_q + 2'd1;
            res_status_d = cap_q;
            state_d      = S_REPORT;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_REPORT: begin
        // Only an error status leaves the session open for a retry.
        if (cap_q != 2'b01) begin
          sess_d = 1'b0;
        end
        state_d = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d = (state_d == S_FILL);
    start_d    = (state_d == S_START);
    busy_d     = (state_d != S_FILL);
    rv_d       = (state_d == S_REPORT);
    en_d       = (state_d == S_SEND) && (gap_d == 4'd0);
    data_d     = en_d ? mem_q[idx_d] : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      idx_q        <= '0;
      gap_q        <= '0;
      cnt_q        <= '0;
      cap_q        <= '0;
      sess_q       <= 1'b0;
      att_q        <= '0;
      res_status_q <= '0;
      in_ready_q   <= 1'b0;
      start_q      <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      rv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      sess_q       <= sess_d;
      att_q        <= att_d;
      res_status_q <= res_status_d;
      in_ready_q   <= in_ready_d;
      start_q      <= start_d;
      en_q         <= en_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      rv_q         <= rv_d;
    end
  end

  // Buffer contents need no reset: idx restarts at 0 and every byte is rewritten before use.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      mem_q[idx_q] <= in_data;
    end
  end

  assign in_ready      = in_ready_q;
  assign start         = start_q;
  assign input_enable  = en_q;
  assign input_data    = data_q;
  assign busy          = busy_q;
  assign result_valid  = rv_q;
  assign result_status = res_status_q;
  assign attempt_count = att_q;

endmodule
